// File: rtl/ctrl_rega.sv
// ctrl_rega: tank-fill / irrigation controller.
//
// Three raw tank probes are debounced into filtered levels l/m/h. A small FSM
// keeps the tank topped up with the pump and runs the sprinkler valve when
// the soil asks for water. It latches into FAULT when the levels become
// inconsistent or when a fill takes too long. FAULT is left only by reset.
//
// Parameters
//   DEB  consecutive differing cycles before a filtered level follows its raw probe (1..255)
//   TMO  maximum cycles allowed in FILL before a timeout fault (1..65535)
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   s_l, s_m, s_h  raw tank probes, 1 = water present
//   umid           soil-dry request, used unfiltered
//   l, m, h        debounced probe levels
//   vs             sprinkler valve enable
//   bs             pump enable
//   err            filtered levels are not a thermometer code
//   flt            controller is in FAULT
//   st             state code: INIT=0, IDLE=1, FILL=2, IRRIG=3, FAULT=4
module ctrl_rega #(
    parameter int unsigned DEB = 4,
    parameter int unsigned TMO = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_l,
    input  logic       s_m,
    input  logic       s_h,
    input  logic       umid,
    output logic       l,
    output logic       m,
    output logic       h,
    output logic       vs,
    output logic       bs,
    output logic       err,
    output logic       flt,
    output logic [2:0] st
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_FILL  = 3'd2,
        S_IRRIG = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [7:0]  DEB_LAST  = 8'(DEB - 1);
    localparam logic [7:0]  INIT_LAST = 8'(DEB);
    localparam logic [15:0] TMO_LAST  = 16'(TMO - 1);

    logic [2:0]  w_raw;
    logic [2:0]  r_filt;
    logic [7:0]  r_dcnt [3];
    logic        r_err;
    logic        w_lvl_ok;

    state_t      r_state;
    state_t      w_nstate;
    logic [7:0]  r_icnt;
    logic [15:0] r_tcnt;
    logic        w_tmo;
    logic        r_vs;
    logic        r_bs;
    logic        r_flt;
    logic        w_vs;
    logic        w_bs;
    logic        w_flt;

    assign w_raw = {s_h, s_m, s_l};

    // Per-probe debounce: the counter runs only while raw disagrees with the
    // filtered value; the DEB-th consecutive disagreement commits the change.
    for (genvar g = 0; g < 3; g++) begin : g_deb
        always_ff @(posedge clk) begin
            if (rst) begin
                r_filt[g] <= 1'b0;
                r_dcnt[g] <= '0;
            end else if (w_raw[g] == r_filt[g]) begin
                r_dcnt[g] <= '0;
            end else if (r_dcnt[g] == DEB_LAST) begin
                r_filt[g] <= w_raw[g];
                r_dcnt[g] <= '0;
            end else begin
                r_dcnt[g] <= r_dcnt[g] + 8'd1;
            end
        end
    end

    // Valid levels fill from the bottom: 000, 001, 011, 111.
    assign w_lvl_ok = (r_filt == 3'b000) || (r_filt == 3'b001) ||
                      (r_filt == 3'b011) || (r_filt == 3'b111);

    assign w_tmo = (r_tcnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_state <= S_INIT;
            r_icnt  <= '0;
            r_tcnt  <= '0;
            r_vs    <= 1'b0;
            r_bs    <= 1'b0;
            r_flt   <= 1'b0;
        end else begin
            r_err   <= ~w_lvl_ok;
            r_state <= w_nstate;
            r_vs    <= w_vs;
            r_bs    <= w_bs;
            r_flt   <= w_flt;
            if (r_state == S_INIT) begin
                r_icnt <= r_icnt + 8'd1;
            end
            // Cleared on the entry edge so the first FILL cycle sees zero.
            if (w_nstate == S_FILL && r_state != S_FILL) begin
                r_tcnt <= '0;
            end else if (r_state == S_FILL) begin
                r_tcnt <= r_tcnt + 16'd1;
            end
        end
    end

    // Next state, with the outputs decoded from the state being entered so
    // the registered outputs line up with st.
    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_INIT: begin
                if (r_icnt == INIT_LAST) w_nstate = S_IDLE;
            end
            S_IDLE: begin
                if (r_err)           w_nstate = S_FAULT;
                else if (!r_filt[0]) w_nstate = S_FILL;
                else if (umid)       w_nstate = S_IRRIG;
            end
            S_FILL: begin
                // h wins over a same-edge timeout.
                if (r_err)          w_nstate = S_FAULT;
                else if (r_filt[2]) w_nstate = S_IDLE;
                else if (w_tmo)     w_nstate = S_FAULT;
            end
            S_IRRIG: begin
                if (r_err)           w_nstate = S_FAULT;
                else if (!r_filt[0]) w_nstate = S_FILL;
                else if (!umid)      w_nstate = S_IDLE;
            end
            S_FAULT: w_nstate = S_FAULT;
            default: w_nstate = S_FAULT;
        endcase

        w_vs  = (w_nstate == S_IRRIG);
        w_bs  = (w_nstate == S_FILL);
        w_flt = (w_nstate == S_FAULT);
    end

    assign l   = r_filt[0];
    assign m   = r_filt[1];
    assign h   = r_filt[2];
    assign err = r_err;
    assign vs  = r_vs;
    assign bs  = r_bs;
    assign flt = r_flt;
    assign st  = r_state;

endmodule

// File: doc/ctrl_rega.md
CTRL_REGA -- requirements
Module: ctrl_rega

Interface
REQ-001 Parameter DEB, default 4, range 1..255: consecutive cycles a raw probe must differ from its filtered value before the filtered value changes.
REQ-002 Parameter TMO, default 1000, range 1..65535: maximum cycles allowed in FILL before a timeout fault.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 s_l / s_m / s_h  input  1 each  raw tank probes (low / medium / high); 1 = water present.
REQ-006 umid  input  1  soil-dry request, 1 = irrigation wanted; synchronous to clk, used unfiltered.
REQ-007 l / m / h  output  1 each  debounced probe levels, registered.
REQ-008 vs  output  1  valve (sprinkler) enable, registered.
REQ-009 bs  output  1  pump enable, registered.
REQ-010 err  output  1  filtered levels are not a valid thermometer code, registered.
REQ-011 flt  output  1  controller in FAULT, registered.
REQ-012 st  output  3  state code: INIT=0, IDLE=1, FILL=2, IRRIG=3, FAULT=4.

Function
REQ-013 Each probe has its own 8-bit debounce counter; raw equal to filtered -> counter cleared.
REQ-014 Raw differs from filtered -> counter increments; on the DEB-th consecutive differing edge, filtered takes raw and the counter clears.
REQ-015 A pulse shorter than DEB cycles never changes the filtered output.
REQ-016 err is 1 iff filtered {h,m,l} is not one of 000, 001, 011, 111; it updates on the edge after the filtered levels change.
REQ-017 INIT holds for DEB+1 cycles after reset release, vs=bs=0, then -> IDLE.
REQ-018 IDLE, vs=bs=0; priority: err -> FAULT; else l=0 -> FILL; else umid=1 -> IRRIG.
REQ-019 FILL, bs=1, vs=0; priority: err -> FAULT; else h=1 -> IDLE; else timeout -> FAULT.
REQ-020 FILL timeout counter is 16 bits, clears on FILL entry, and increments each FILL cycle; timeout = FILL TMO cycles after entry with h still 0.
REQ-021 h rising and timeout on the same edge -> IDLE (no fault).
REQ-022 IRRIG, vs=1, bs=0; priority: err -> FAULT; else l=0 -> FILL; else umid=0 -> IDLE.
REQ-023 FAULT, vs=bs=0, flt=1; FAULT is sticky and left only by rst, even after err clears.
REQ-024 vs and bs are never 1 in the same cycle.
REQ-025 vs, bs, flt and st reflect the state entered at the same edge; the FSM reacts one edge after the filtered or err change that causes a transition.

Reset
REQ-026 With rst=1 at an edge: l=m=h=0, all counters 0, err=0, vs=bs=flt=0, st=INIT.
REQ-027 rst asserted mid-FILL, mid-IRRIG or in FAULT -> same values at that edge; in-progress debounce and timeout counts are discarded.

Verification (DEB=4, TMO=20)
REQ-028 Reset released, raw probes 000, umid=0 -> st=0 for 5 cycles, then st=1, next edge st=2 with bs=1.
REQ-029 In IDLE with l=1, s_l pulses low for 3 cycles -> l stays 1, st stays 1; pulse held 4 cycles -> l=0 and st=2 one edge later.
REQ-030 In FILL, s_l/s_m/s_h raised together and held -> l=m=h=1 after 4 edges, next edge st=1 and bs=0.
REQ-031 In FILL with s_h held 0 -> st=4 and flt=1 at the 20th edge after entry; remains 4 with any input until rst.
REQ-032 Raw {s_h,s_m,s_l}=101 held -> err=1 one edge after the filtered update, st=4 the edge after.
REQ-033 In IRRIG (umid=1, levels 111), all probes dropped to 0 -> l=0 after 4 edges, next edge st=2, vs=0, bs=1.
